// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit that owns the HI/LO registers.
// Latency: MULT_CYCLES (multiply family) or DIV_CYCLES (divide) Busy cycles; HI/LO update on the edge Busy drops.
// Backpressure: Busy is exported to the hazard unit; a Start seen while Busy is dropped, not queued.
//
// Ports:
//   Clk, Reset        rising-edge clock, synchronous active-high reset
//   A, B              forwarded rs/rt operands (A is also the MTHI/MTLO source)
//   Op                0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
//   Start             launch Op with A/B (accepted only when idle and Op is valid)
//   WriteHi, WriteLo  MTHI / MTLO, honoured only when idle and Start is low
//   Busy              operation in flight
//   HI, LO            architectural HI/LO registers
//
// Build option: define MULDIV_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU ops (4-7).
// Without it those opcodes are treated as invalid and Start is ignored for them.

module muldiv_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  Op,
    input  logic        Start,
    input  logic        WriteHi,
    input  logic        WriteLo,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [2:0]       op_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    logic             op_valid;
    logic             start_acc;
    logic             done;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
`ifdef MULDIV_MADD_EN
    assign op_valid = 1'b1;
`else
    assign op_valid = ~Op[2];
`endif

    assign start_acc = (state_q == IDLE) && Start && op_valid;
    // Counter is about to reach zero on this edge: the operation completes now.
    assign done      = (state_q == RUN) && (cnt_q == CNT_ONE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_acc) state_d = RUN;
            RUN:  if (done)      state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Result datapath, evaluated from the latched operands
    // ------------------------------------------------------------------
    logic        is_signed;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [63:0] res;

    // Even opcodes are the signed variants.
    assign is_signed = ~op_q[0];

    // A 64x64 product of sign/zero-extended operands, kept mod 2^64, equals the
    // signed/unsigned 32x32 product, so one multiplier serves both flavours.
    assign ext_a = {{32{is_signed & a_q[31]}}, a_q};
    assign ext_b = {{32{is_signed & b_q[31]}}, b_q};
    assign prod  = ext_a * ext_b;

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend's sign. 0x80000000 / -1 falls out
    // naturally as quotient 0x80000000, remainder 0.
    assign a_neg = is_signed & a_q[31];
    assign b_neg = is_signed & b_q[31];
    assign a_mag = a_neg ? (32'd0 - a_q) : a_q;
    assign b_mag = b_neg ? (32'd0 - b_q) : b_q;
    assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    assign div_q = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign div_r = a_neg ? (32'd0 - r_mag) : r_mag;

`ifdef MULDIV_MADD_EN
    logic [63:0] acc;
    // Accumulator is the live HI/LO at completion time.
    assign acc = {hi_q, lo_q};
`endif

    always_comb begin
        res = prod;
        if (!op_q[2] && op_q[1]) begin
            if (b_q == 32'd0) begin
                res = {a_q, 32'hFFFF_FFFF};
            end else begin
                res = {div_r, div_q};
            end
        end
`ifdef MULDIV_MADD_EN
        else if (op_q[2]) begin
            res = op_q[1] ? (acc - prod) : (acc + prod);
        end
`endif
    end

    // ------------------------------------------------------------------
    // Operand latch, counter and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            if (start_acc) begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= Op;
                cnt_q <= (Op[2:1] == 2'b01) ? DIV_N : MULT_N;
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q - CNT_ONE;
            end

            if (done) begin
                hi_q <= res[63:32];
                lo_q <= res[31:0];
            end else if ((state_q == IDLE) && !Start) begin
                if (WriteHi) hi_q <= A;
                if (WriteLo) lo_q <= A;
            end
        end
    end

    assign Busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  Op;
    logic        Start;
    logic        WriteHi;
    logic        WriteLo;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int tests = 0;
    int fails = 0;

    // Reference HI/LO
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 Clk = ~Clk;

    muldiv_unit #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .A       (A),
        .B       (B),
        .Op      (Op),
        .Start   (Start),
        .WriteHi (WriteHi),
        .WriteLo (WriteLo),
        .Busy    (Busy),
        .HI      (HI),
        .LO      (LO)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural result of an op from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        bit          sgn;
        sgn = (op[0] == 1'b0);
        sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb  = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        p   = sa * sb;
        case (op)
            3'd2, 3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd0, 3'd1: return p;
            3'd4, 3'd5: return acc + p;
            default:    return acc - p;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called and returns at a negedge. Launches op, scrambles inputs while busy,
    // checks Busy length, HI/LO hold during the run and the final result.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit also_mt);
        int          n;
        int          cnt;
        logic [63:0] exp;
        A = a; B = b; Op = op; Start = 1'b1;
        WriteHi = also_mt; WriteLo = also_mt;
        @(negedge Clk);
        Start = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
        n   = (op == 3'd2 || op == 3'd3) ? DC : MC;
        cnt = 0;
        while (Busy === 1'b1 && cnt <= n + 5) begin
            cnt++;
            check("hold", {HI, LO}, {m_hi, m_lo});
            A = $urandom; B = $urandom; Op = 3'($urandom);
            @(negedge Clk);
        end
        check("busy_len", 64'(cnt), 64'(n));
        exp = model(op, a, b, {m_hi, m_lo});
        {m_hi, m_lo} = exp;
        check("result", {HI, LO}, exp);
    endtask

    task automatic mt(input bit hi_en, input bit lo_en, input logic [31:0] val);
        A = val; WriteHi = hi_en; WriteLo = lo_en;
        @(negedge Clk);
        WriteHi = 1'b0; WriteLo = 1'b0;
        if (hi_en) m_hi = val;
        if (lo_en) m_lo = val;
        check("mt", {HI, LO}, {m_hi, m_lo});
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int       cnt;
        logic [2:0] rop;
        Reset = 1'b1; A = '0; B = '0; Op = '0; Start = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(negedge Clk);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_hilo", {HI, LO}, 64'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // Directed vectors, with literal expectations as well as the model
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_k", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("multu_k", {HI, LO}, {32'h0000_0002, 32'hFFFF_FFFA});
        run_op(3'd3, 32'd7, 32'd2, 1'b0);
        check("divu_k", {HI, LO}, {32'd1, 32'd3});
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_neg_k", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(3'd3, 32'd5, 32'd0, 1'b0);
        check("div0_k", {HI, LO}, {32'd5, 32'hFFFF_FFFF});
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("divovf_k", {HI, LO}, {32'd0, 32'h8000_0000});

        // Start accepted together with MTHI/MTLO: the write is dropped
        run_op(3'd1, 32'd5, 32'd6, 1'b1);

        // Second Start plus MTLO during a DIV: both ignored, nothing queued
        A = 32'd100; B = 32'd7; Op = 3'd2; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        cnt = 0;
        while (Busy === 1'b1 && cnt < 20) begin
            cnt++;
            if (cnt == 2) begin
                A = 32'd9; B = 32'd3; Op = 3'd0; Start = 1'b1; WriteLo = 1'b1;
            end else begin
                Start = 1'b0; WriteLo = 1'b0;
            end
            @(negedge Clk);
        end
        Start = 1'b0; WriteLo = 1'b0;
        check("ovl_busy_len", 64'(cnt), 64'(DC));
        {m_hi, m_lo} = model(3'd2, 32'd100, 32'd7, {m_hi, m_lo});
        check("ovl_result", {HI, LO}, {m_hi, m_lo});
        @(negedge Clk);
        check("ovl_noqueue", 64'(Busy), 64'd0);

        // MT writes
        mt(1'b1, 1'b0, 32'h0000_1234);
        check("mthi_k", 64'(HI), 64'h1234);
        mt(1'b0, 1'b1, 32'hCAFE_F00D);
        mt(1'b1, 1'b1, 32'h5A5A_A5A5);

        // Reset during the third Busy cycle aborts the divide
        A = 32'd1000; B = 32'd3; Op = 3'd2; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        m_hi = '0; m_lo = '0;
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_hilo", {HI, LO}, 64'd0);
        repeat (20) @(negedge Clk);
        check("abort_busy_late", 64'(Busy), 64'd0);
        check("abort_hilo_late", {HI, LO}, 64'd0);

`ifdef MULDIV_MADD_EN
        mt(1'b1, 1'b1, 32'd0);
        mt(1'b0, 1'b1, 32'd10);
        run_op(3'd4, 32'd3, 32'd4, 1'b0);
        check("madd_k", {HI, LO}, {32'd0, 32'd22});
        run_op(3'd7, 32'd1, 32'd30, 1'b0);
        check("msubu_k", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFF8});
`else
        mt(1'b1, 1'b1, 32'h0BAD_0BAD);
        for (int op = 4; op < 8; op++) begin
            A = 32'd3; B = 32'd4; Op = 3'(op); Start = 1'b1;
            @(negedge Clk);
            Start = 1'b0;
            check("invalid_busy", 64'(Busy), 64'd0);
            check("invalid_hilo", {HI, LO}, {m_hi, m_lo});
        end
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                mt(1'($urandom), 1'($urandom), pick());
            end
`ifdef MULDIV_MADD_EN
            rop = 3'($urandom_range(0, 7));
`else
            rop = 3'($urandom_range(0, 3));
`endif
            run_op(rop, pick(), pick(), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
